serial_addsub_n: RTL
====================

Name: serial_addsub_n

Overview:
Parametrised bit-serial adder/subtractor, successor to the single-bit serial adder. It accepts two WIDTH-bit operands with a start/done handshake and processes them LSB-first, one bit per clock, through a single full-adder cell and carry flop. It supports add and two's-complement subtract modes and reports final carry and signed overflow. It also streams each sum bit as it is produced, for downstream serial consumers in the arithmetic datapath.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request a new operation; sampled only when idle or in the done cycle
mode  input  1  0 = add (a+b), 1 = subtract (a-b); captured with start
a  input  WIDTH  operand A; captured with start
b  input  WIDTH  operand B; captured with start
busy  output  1  high while bits are being processed
done  output  1  one-cycle pulse: result, carry_out and overflow are valid
result  output  WIDTH  final sum/difference; holds until the next operation completes
carry_out  output  1  final carry; in subtract mode 1 = no borrow (a >= b unsigned)
overflow  output  1  signed overflow: carry into MSB XOR carry out of MSB
sum_bit  output  1  serial sum bit for the current position
bit_valid  output  1  sum_bit is valid this cycle

Behaviour:
- Decided: one clock, clk; reset rst is synchronous and active-high.
- Reset: the FSM returns to IDLE; busy, done, result, carry_out, overflow, sum_bit and bit_valid all go to 0; internal shift registers, carry and bit counter clear.
- Reset mid-operation aborts the operation immediately. No done pulse is produced, and result is cleared to 0.
- FSM states:
  - IDLE -> RUN on start=1.
  - RUN -> DONE after the WIDTH-th bit.
  - DONE -> RUN if start=1, else DONE -> IDLE. DONE lasts exactly one cycle.
- Load edge (start accepted):
  - A and B shift registers load a and b.
  - Carry flop loads mode (the +1 for two's complement).
  - Mode is latched and bit counter = 0.
  - busy = 1 from the next cycle.
- Each RUN edge i (i = 0..WIDTH-1), using bit position i:
  - bb = b_sh[0] XOR mode_q.
  - s = a_sh[0] XOR bb XOR c.
  - c_next = majority(a_sh[0], bb, c).
  - s shifts into the result-assembly register from the MSB side, and both operand registers shift right.
  - sum_bit <= s and bit_valid <= 1 for one cycle per bit.
- Final bit edge (i = WIDTH-1):
  - result <= assembled value.
  - carry_out <= c_next.
  - overflow <= c (carry into MSB) XOR c_next.
  - done <= 1 and busy <= 0.
- Latency: start sampled at edge E0; done is high in the cycle following edge E0+WIDTH. Throughput is one operation per WIDTH+1 cycles when start is held high continuously.
- start while busy: ignored; the operands and mode in flight are unaffected.
- start during the done cycle: accepted, back-to-back. The new load happens on that edge and busy rises the next cycle.
- Input stability: a, b and mode are don't-care except on the load edge.
- Output holds: result, carry_out and overflow hold their values from done until the next operation's final edge or reset. done and bit_valid are single-cycle pulses.
- The final bit_valid pulse coincides with the done cycle.
- Idle outputs: bit_valid = 0 and sum_bit = 0 when not in RUN output cycles.

Test Plan:
1. WIDTH=8, add, a=0x5A, b=0x33 -> done 9 cycles after the start edge; result=0x8D, carry_out=0, overflow=1; sum_bit sequence LSB-first = 1,0,1,1,0,0,0,1.
2. Add, a=0xFF, b=0x01 -> result=0x00, carry_out=1, overflow=0.
3. Subtract, a=0x10, b=0x20 -> result=0xF0, carry_out=0 (borrow), overflow=0. Subtract, a=0x80, b=0x01 -> result=0x7F, carry_out=1, overflow=1.
4. Start add 0x12+0x34, pulse start again with a=0xFF, b=0xFF at bit 3 -> second start ignored; result=0x46; exactly one done pulse.
5. Start held high continuously: 0x01+0x01, then sub 0x05-0x03 loaded in the done cycle -> results 0x02 then 0x02, with done pulses 9 cycles apart.
6. Assert rst at bit 4 of 0x5A+0x33 -> next cycle all outputs 0, FSM idle, no done pulse; a subsequent operation computes correctly.

Source files
------------

// File: rtl/serial_addsub_n.sv
// serial_addsub_n: bit-serial adder/subtractor.
// Operands are captured on start and processed LSB-first, one bit per clock,
// through a single full-adder cell and carry flop. Subtract is a + ~b + 1:
// b is inverted bit by bit and the carry flop is preloaded with 1.
// Each sum bit is streamed on sum_bit/bit_valid as it is produced, and the
// assembled result, final carry and signed overflow are presented with a
// one-cycle done pulse.
module serial_addsub_n #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             sum_bit,
    output logic             bit_valid
);

    // Bit counter only needs to reach WIDTH-1; WIDTH >= 2 keeps this >= 1 bit.
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Full-adder sum output.
    function automatic logic fa_sum(input logic x, input logic y, input logic ci);
        return x ^ y ^ ci;
    endfunction

    // Full-adder carry output (majority of the three inputs).
    function automatic logic fa_carry(input logic x, input logic y, input logic ci);
        return (x & y) | (x & ci) | (y & ci);
    endfunction

    state_t             state_q;
    logic [WIDTH-1:0]   a_sh_q;
    logic [WIDTH-1:0]   b_sh_q;
    logic [WIDTH-1:0]   res_sh_q;
    logic               c_q;
    logic               mode_q;
    logic [CNT_W-1:0]   cnt_q;

    logic               busy_q;
    logic               done_q;
    logic [WIDTH-1:0]   result_q;
    logic               carry_out_q;
    logic               overflow_q;
    logic               sum_bit_q;
    logic               bit_valid_q;

    logic               bb_d;
    logic               s_d;
    logic               c_d;
    logic [WIDTH-1:0]   asm_d;
    logic               last_d;
    logic               load_d;

    // Full-adder cell on the current bit position plus result assembly.
    always_comb begin
        bb_d   = b_sh_q[0] ^ mode_q;
        s_d    = fa_sum(a_sh_q[0], bb_d, c_q);
        c_d    = fa_carry(a_sh_q[0], bb_d, c_q);
        asm_d  = {s_d, res_sh_q[WIDTH-1:1]};
        last_d = (cnt_q == LAST_BIT);
        // start is honoured only from IDLE or in the single DONE cycle.
        load_d = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    end

    // Control FSM, operand/result shift registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            res_sh_q    <= '0;
            c_q         <= 1'b0;
            mode_q      <= 1'b0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            result_q    <= '0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
            sum_bit_q   <= 1'b0;
            bit_valid_q <= 1'b0;
        end else begin
            // Pulses default low; RUN reasserts them for each produced bit.
            done_q      <= 1'b0;
            sum_bit_q   <= 1'b0;
            bit_valid_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (load_d) begin
                        state_q <= S_RUN;
                        busy_q  <= 1'b1;
                    end
                end

                S_RUN: begin
                    a_sh_q      <= a_sh_q >> 1;
                    b_sh_q      <= b_sh_q >> 1;
                    res_sh_q    <= asm_d;
                    c_q         <= c_d;
                    cnt_q       <= cnt_q + CNT_W'(1);
                    sum_bit_q   <= s_d;
                    bit_valid_q <= 1'b1;
                    if (last_d) begin
                        // c_q is the carry into the MSB, c_d the carry out of it.
                        result_q    <= asm_d;
                        carry_out_q <= c_d;
                        overflow_q  <= c_q ^ c_d;
                        done_q      <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= S_DONE;
                    end
                end

                S_DONE: begin
                    if (load_d) begin
                        state_q <= S_RUN;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase

            // Operand capture; carry preload supplies the +1 of two's complement.
            if (load_d) begin
                a_sh_q   <= a;
                b_sh_q   <= b;
                res_sh_q <= '0;
                c_q      <= mode;
                mode_q   <= mode;
                cnt_q    <= '0;
            end
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign result    = result_q;
    assign carry_out = carry_out_q;
    assign overflow  = overflow_q;
    assign sum_bit   = sum_bit_q;
    assign bit_valid = bit_valid_q;

endmodule
